bus_receiver: RTL and testbench

//  Listening end of the shared tri-state data bus. Each bus driver places a word with

---
 rtl/veririsc_bus_pkg.sv | 11 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/bus_receiver.sv | 67 ++++++
 tb/tb_bus_receiver.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/veririsc_bus_pkg.sv
// Shared sizing for the bus receiver slice.
//   WORD_W    : default bus/data word width
//   BUF_DEPTH : default receive FIFO depth (power of two, >= 2)
//   PTR_W     : FIFO pointer width derived from BUF_DEPTH
//   CNT_W     : occupancy counter width, holds 0..BUF_DEPTH
package veririsc_bus_pkg;
  localparam int WORD_W    = 8;
  localparam int BUF_DEPTH = 4;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = $clog2(BUF_DEPTH) + 1;
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with a separate occupancy counter.
// Callers qualify push/pop; this block never refuses them.
//   clk, rst : clock, synchronous active-high reset (pointers/count only)
//   push     : write wdata at wr_ptr
//   wdata    : word to write
//   pop      : advance rd_ptr
//   rdata    : storage[rd_ptr], mux only (no register after storage)
//   count    : occupancy 0..depth
//   full     : count == depth
//   empty    : count == 0
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [width-1:0]           wdata,
  input  logic                       pop,
  output logic [width-1:0]           rdata,
  output logic [$clog2(depth):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth) + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(depth);

  logic [depth-1:0][width-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               cnt;

  // Storage is intentionally not reset; out_data zero-forcing hides stale words.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CNT_MAX);
  assign empty = (cnt == '0);
endmodule

// File: rtl/bus_receiver.sv
// Listening end of the shared tri-state data bus. Captures the bus when a load
// strobe meets a driven bus, queues words in sync_fifo, and hands them off over
// valid/ready. Strobes on a floating bus and captures into a full FIFO raise
// sticky error flags.
//   clk, rst            : clock, synchronous active-high reset
//   data_bus/en/ld      : bus word, driven indicator, load strobe
//   out_data/valid/ready: downstream handshake (out_data = 0 while empty)
//   count, full         : FIFO occupancy status, decoded from registered count
//   float_err, ovf_err  : sticky error flags, cleared by err_clr (set wins)
module bus_receiver
  import veririsc_bus_pkg::*;
#(
  parameter int width = WORD_W,
  parameter int depth = BUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [width-1:0]       data_bus,
  input  logic                   data_en,
  input  logic                   data_ld,
  output logic [width-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(depth):0] count,
  output logic                   full,
  output logic                   float_err,
  output logic                   ovf_err,
  input  logic                   err_clr
);
  logic             cap, push, pop, empty, float_hit, ovf_hit;
  logic [width-1:0] rdata;

  assign cap       = data_ld & data_en;
  assign pop       = out_valid & out_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign push      = cap & (~full | pop);
  assign float_hit = data_ld & ~data_en;
  assign ovf_hit   = cap & full & ~pop;

  sync_fifo #(.width(width), .depth(depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (data_bus),
    .pop   (pop),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  // Storage is unreset; forcing zero keeps X from leaving the block.
  assign out_data  = empty ? '0 : rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      float_err <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      if (float_hit)    float_err <= 1'b1;
      else if (err_clr) float_err <= 1'b0;
      if (ovf_hit)      ovf_err   <= 1'b1;
      else if (err_clr) ovf_err   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bus_receiver.sv
module tb_bus_receiver;
  logic       clk = 1'b0;
  logic       rst, data_en, data_ld, out_ready, err_clr;
  logic [7:0] data_bus, out_data;
  logic       out_valid, full, float_err, ovf_err;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic       mf, mo;
  int         maxcnt;
  logic [7:0] last_pop;

  always #5 clk = ~clk;

  bus_receiver dut (
    .clk(clk), .rst(rst), .data_bus(data_bus), .data_en(data_en),
    .data_ld(data_ld), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .full(full),
    .float_err(float_err), .ovf_err(ovf_err), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    data_bus = d; data_en = 1'b1; data_ld = 1'b1;
    cyc();
    data_ld = 1'b0; data_en = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid === 1'b1; i++) cyc();
    chk("drain_done", out_valid, 0);
    out_ready = 1'b0;
  endtask

  // Scoreboard: at the falling edge the inputs for the next rising edge are
  // stable; compare DUT state against the queue, then apply that edge's effect.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      q.delete(); mf = 1'b0; mo = 1'b0;
    end else if (rst === 1'b0) begin
      logic pp, cp, ps;
      chk("sb_count", count, q.size());
      chk("sb_valid", out_valid, q.size() != 0);
      chk("sb_full", full, q.size() == 4);
      chk("sb_float", float_err, mf);
      chk("sb_ovf", ovf_err, mo);
      if (q.size() == 0) chk("sb_zero", out_data, 0);
      if (int'(count) > maxcnt) maxcnt = int'(count);
      pp = (q.size() != 0) && out_ready;
      cp = data_ld && data_en;
      ps = cp && (q.size() < 4 || pp);
      if (pp) begin
        chk("sb_data", out_data, q[0]);
        last_pop = q[0];
        void'(q.pop_front());
      end
      if (ps) q.push_back(data_bus);
      if (data_ld && !data_en) mf = 1'b1;
      else if (err_clr)        mf = 1'b0;
      if (cp && q.size() == 4 && !pp && !ps) mo = 1'b1;
      else if (err_clr)                      mo = 1'b0;
    end
  end

  initial begin
    rst = 1'b1; data_en = 1'b0; data_ld = 1'b0; out_ready = 1'b0;
    err_clr = 1'b0; data_bus = 8'h00; maxcnt = 0; last_pop = 8'h00;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_float", float_err, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_data", out_data, 0);

    // single capture then pop
    load(8'hA5);
    chk("cap_valid", out_valid, 1);
    chk("cap_data", out_data, 8'hA5);
    chk("cap_count", count, 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("pop_valid", out_valid, 0);
    chk("pop_count", count, 0);

    // fill plus overflow
    for (int i = 1; i <= 4; i++) load(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    load(8'h05);
    chk("ovf_flag", ovf_err, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", out_data, 8'h01);
    drain();
    chk("ovf_last", last_pop, 8'h04);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("ovf_clr", ovf_err, 0);

    // strobe on floating bus, clear, then set-vs-clear priority
    data_bus = 8'hFF; data_ld = 1'b1; data_en = 1'b0;
    cyc();
    data_ld = 1'b0;
    chk("float_flag", float_err, 1);
    chk("float_count", count, 0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("float_clr", float_err, 0);
    data_ld = 1'b1; err_clr = 1'b1;
    cyc();
    data_ld = 1'b0; err_clr = 1'b0;
    chk("float_prio", float_err, 1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) load(8'h31 + 8'(i));
    chk("fpp_pre", count, 4);
    out_ready = 1'b1;
    load(8'h77);
    chk("fpp_count", count, 4);
    chk("fpp_ovf", ovf_err, 0);
    chk("fpp_head", out_data, 8'h32);
    drain();
    chk("fpp_last", last_pop, 8'h77);

    // streaming across pointer wrap
    maxcnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) load(8'h10 + 8'(i));
    drain();
    chk("wrap_last", last_pop, 8'h19);
    chk("wrap_max", maxcnt, 1);

    // reset with words queued and flags set
    load(8'hC1); load(8'hC2); load(8'hC3);
    data_ld = 1'b1; cyc(); data_ld = 1'b0;
    chk("mr_pre", count, 3);
    chk("mr_pre_float", float_err, 1);
    out_ready = 1'b1;
    rst = 1'b1; cyc(); rst = 1'b0;
    out_ready = 1'b0;
    chk("mr_count", count, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 0);
    chk("mr_float", float_err, 0);
    chk("mr_ovf", ovf_err, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
